// File: rtl/profile_sequencer.sv
// rtl/profile_sequencer.sv - table-driven sequencer for the four internal DDS profile selects
//
// Optional feature macro: PROFILE_SEQ_TRIG_EN (adds trig port and WAIT_TRIG hold state)
//
// Ports:
//   sync_clk         sequencer clock, rising edge
//   rst              synchronous active-high reset
//   cfg_we/addr/data table write port; data = {dwell, wait_trig, ch3, ch2, ch1, ch0}
//   last_idx         index of final entry, latched at start
//   loop_en          wrap to entry 0 after last_idx, latched at start
//   start / stop     single-cycle start and abort requests (stop wins)
//   trig             external advance pulse (PROFILE_SEQ_TRIG_EN only)
//   chN_profile_int  registered 3-bit profile selects, all from one register stage
//   profile_switch   internal profiles own the channels
//   busy             sequence in progress
//   done             one-cycle pulse at one-shot completion
//   cur_idx          index of the entry currently on the outputs
module profile_sequencer #(
    parameter int  DEPTH   = 16,
    parameter int  DWELL_W = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int EW      = DWELL_W + 13
) (
    input  logic          sync_clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [EW-1:0] cfg_data,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
`ifdef PROFILE_SEQ_TRIG_EN
    input  logic          trig,
`endif
    output logic [2:0]    ch0_profile_int,
    output logic [2:0]    ch1_profile_int,
    output logic [2:0]    ch2_profile_int,
    output logic [2:0]    ch3_profile_int,
    output logic          profile_switch,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx
);

    // ST_ARM is the cycle in which the RAM reads entry 0, so FETCH sees valid data.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [EW-1:0]      mem [DEPTH];
    logic [EW-1:0]      rd_data;
    logic [AW-1:0]      rd_addr;

    logic [2:0]         state;
    logic [AW-1:0]      last_q;
    logic               loop_q;
    logic [DWELL_W-1:0] cnt;
    logic               wait_q;
    logic               ps_clr;

    logic               is_last;
    logic [AW-1:0]      nxt_idx;
    logic               expire;
    logic               step;
    logic               park;
    logic               finish;
    logic               load;
    logic [AW-1:0]      load_idx;

    function automatic logic [AW-1:0] next_of(input logic [AW-1:0] idx,
                                              input logic [AW-1:0] last);
        next_of = (idx == last) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        is_last  = (cur_idx == last_q);
        nxt_idx  = next_of(cur_idx, last_q);
        expire   = (state == ST_RUN) && (cnt == '0);
`ifdef PROFILE_SEQ_TRIG_EN
        step     = (expire && !wait_q) || ((state == ST_WAIT) && trig);
        park     = expire && wait_q;
`else
        step     = expire;
        park     = 1'b0;
`endif
        finish   = step && is_last && !loop_q;
        load     = (state == ST_FETCH) || (step && !finish);
        load_idx = (state == ST_FETCH) ? '0 : nxt_idx;

        // rd_data must always hold the entry that follows whatever is on the
        // outputs after this edge; on a load edge that is one index further on,
        // which is what lets dwell=0 entries play back-to-back.
        case (state)
            ST_FETCH:        rd_addr = next_of('0, last_q);
            ST_RUN, ST_WAIT: rd_addr = load ? next_of(nxt_idx, last_q) : nxt_idx;
            default:         rd_addr = '0;
        endcase
    end

    always_ff @(posedge sync_clk) begin
        if (cfg_we) begin
            mem[cfg_addr] <= cfg_data;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge sync_clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            ch0_profile_int <= '0;
            ch1_profile_int <= '0;
            ch2_profile_int <= '0;
            ch3_profile_int <= '0;
            profile_switch  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cur_idx         <= '0;
            cnt             <= '0;
            last_q          <= '0;
            loop_q          <= 1'b0;
            wait_q          <= 1'b0;
            ps_clr          <= 1'b0;
        end else begin
            done   <= 1'b0;
            ps_clr <= 1'b0;
            // profile_switch drops one edge after the abort is taken
            if (ps_clr) begin
                profile_switch <= 1'b0;
            end

            if (stop && (state != ST_IDLE)) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                ps_clr <= 1'b1;
            end else if ((state == ST_IDLE) || (state == ST_DONE)) begin
                state <= ST_IDLE;
                if (start && !stop) begin
                    last_q <= last_idx;
                    loop_q <= loop_en;
                    busy   <= 1'b1;
                    state  <= ST_ARM;
                end
            end else if (load) begin
                ch0_profile_int <= rd_data[2:0];
                ch1_profile_int <= rd_data[5:3];
                ch2_profile_int <= rd_data[8:6];
                ch3_profile_int <= rd_data[11:9];
                cur_idx         <= load_idx;
                cnt             <= rd_data[EW-1:13];
                wait_q          <= rd_data[12];
                profile_switch  <= 1'b1;
                state           <= ST_RUN;
            end else if (finish) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
            end else if (park) begin
                state <= ST_WAIT;
            end else if (state == ST_ARM) begin
                state <= ST_FETCH;
            end else if (state == ST_RUN) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifndef PROFILE_SEQ_TRIG_EN
    logic unused_wait;
    assign unused_wait = wait_q;
`endif

endmodule

// File: tb/tb_profile_sequencer.sv
// tb/tb_profile_sequencer.sv - randomized self-checking bench for profile_sequencer
module tb_profile_sequencer;

    localparam int DEPTH   = 16;
    localparam int DWELL_W = 16;
    localparam int AW      = 4;
    localparam int EW      = DWELL_W + 13;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [11:0]   ch;
        logic          ps;
        logic          busy;
        logic          done;
    } obs_t;

    logic          sync_clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [EW-1:0] cfg_data;
    logic [AW-1:0] last_idx;
    logic          loop_en;
    logic          start;
    logic          stop;
`ifdef PROFILE_SEQ_TRIG_EN
    logic          trig;
`endif
    logic [2:0]    ch0_profile_int;
    logic [2:0]    ch1_profile_int;
    logic [2:0]    ch2_profile_int;
    logic [2:0]    ch3_profile_int;
    logic          profile_switch;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_idx;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] tbl [DEPTH];
    obs_t          m_obs;
    obs_t          exp_q [$];
    int            wr_at [$];
    logic [AW-1:0] wr_addr [$];
    logic [EW-1:0] wr_data [$];

    always #5 sync_clk = ~sync_clk;

    profile_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .sync_clk        (sync_clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .last_idx        (last_idx),
        .loop_en         (loop_en),
        .start           (start),
        .stop            (stop),
`ifdef PROFILE_SEQ_TRIG_EN
        .trig            (trig),
`endif
        .ch0_profile_int (ch0_profile_int),
        .ch1_profile_int (ch1_profile_int),
        .ch2_profile_int (ch2_profile_int),
        .ch3_profile_int (ch3_profile_int),
        .profile_switch  (profile_switch),
        .busy            (busy),
        .done            (done),
        .cur_idx         (cur_idx)
    );

    function automatic obs_t observe();
        obs_t o;
        o = {cur_idx, ch3_profile_int, ch2_profile_int, ch1_profile_int, ch0_profile_int,
             profile_switch, busy, done};
        return o;
    endfunction

    function automatic logic [EW-1:0] mk(int c0, int c1, int c2, int c3, int wt, int dw);
        logic [EW-1:0] e;
        e           = '0;
        e[2:0]      = 3'(c0);
        e[5:3]      = 3'(c1);
        e[8:6]      = 3'(c2);
        e[11:9]     = 3'(c3);
        e[12]       = 1'(wt);
        e[EW-1:13]  = DWELL_W'(dw);
        return e;
    endfunction

    // ---------------- reference model: expected per-cycle observation list
    task automatic push(input obs_t o);
        exp_q.push_back(o);
        m_obs = o;
    endtask

    task automatic model_entry(input int idx, input int extra);
        obs_t o;
        int   dw;
        dw     = int'(tbl[idx][EW-1:13]);
        o.idx  = AW'(idx);
        o.ch   = tbl[idx][11:0];
        o.ps   = 1'b1;
        o.busy = 1'b1;
        o.done = 1'b0;
        for (int k = 0; k <= dw + extra; k++) push(o);
    endtask

    // Expected trace from the cycle after the start edge: two setup cycles,
    // each entry for dwell+1 cycles, then done or an abort at index stop_at.
    task automatic build_run(input int lst, input bit lp, input int stop_at,
                             input int trig_idx, input int trig_wait);
        obs_t o;
        int   idx;
        exp_q.delete();
        o      = m_obs;
        o.busy = 1'b1;
        o.done = 1'b0;
        push(o);
        push(o);
        idx = 0;
        while (exp_q.size() < 4000) begin
            model_entry(idx, (idx == trig_idx) ? trig_wait : 0);
            if (stop_at >= 0 && exp_q.size() > stop_at) break;
            if (idx == lst) begin
                if (!lp) begin
                    o      = m_obs;
                    o.busy = 1'b0;
                    o.done = 1'b1;
                    push(o);
                    o.done = 1'b0;
                    push(o);
                    push(o);
                    break;
                end
                idx = 0;
            end else begin
                idx++;
            end
        end
        if (stop_at >= 0) begin
            o = exp_q[stop_at];
            while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
            o.busy = 1'b0;
            o.done = 1'b0;
            push(o);
            o.ps = 1'b0;
            push(o);
            push(o);
        end
    endtask

    // ---------------- stimulus helpers
    task automatic load_entry(input int a, input logic [EW-1:0] d);
        @(negedge sync_clk);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = d;
        @(negedge sync_clk);
        cfg_we   = 1'b0;
        tbl[a]   = d;
    endtask

    task automatic launch(input int lst, input bit lp);
        @(negedge sync_clk);
        last_idx = AW'(lst);
        loop_en  = lp;
        start    = 1'b1;
    endtask

    task automatic check_run(input string name, input int stop_at, input int start_at,
                             input int trig_at);
        obs_t o;
        obs_t e;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge sync_clk);
            start  = 1'b0;
            stop   = 1'b0;
            cfg_we = 1'b0;
`ifdef PROFILE_SEQ_TRIG_EN
            trig   = 1'b0;
`endif
            // last_idx/loop_en are latched at start; scramble them afterwards
            if (i == 0) begin
                last_idx = AW'($urandom);
                loop_en  = 1'($urandom);
            end
            o = observe();
            e = exp_q[i];
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s cycle %0d: got idx=%0d ch=%03h ps=%b busy=%b done=%b, want idx=%0d ch=%03h ps=%b busy=%b done=%b",
                         name, i, o.idx, o.ch, o.ps, o.busy, o.done,
                         e.idx, e.ch, e.ps, e.busy, e.done);
            end
            if (i == stop_at)  stop  = 1'b1;
            if (i == start_at) start = 1'b1;
`ifdef PROFILE_SEQ_TRIG_EN
            if (i == trig_at)  trig  = 1'b1;
`endif
            for (int w = 0; w < wr_at.size(); w++) begin
                if (wr_at[w] == i) begin
                    cfg_we   = 1'b1;
                    cfg_addr = wr_addr[w];
                    cfg_data = wr_data[w];
                end
            end
        end
        @(negedge sync_clk);
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
`ifdef PROFILE_SEQ_TRIG_EN
        trig   = 1'b0;
`endif
        wr_at.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic load_plan_table();
        load_entry(0, mk(1, 2, 3, 4, 0, 3));
        load_entry(1, mk(5, 6, 7, 0, 0, 0));
        load_entry(2, mk(2, 2, 2, 2, 0, 5));
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        obs_t o;
        obs_t z;
        z        = '0;
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        last_idx = '0;
        loop_en  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
`ifdef PROFILE_SEQ_TRIG_EN
        trig     = 1'b0;
`endif
        repeat (3) @(negedge sync_clk);
        o = observe();
        checks++;
        if (o !== z) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", o, z);
        end
        rst   = 1'b0;
        m_obs = '0;
    endtask

    task automatic test_oneshot();
        load_plan_table();
        build_run(2, 1'b0, -1, -1, 0);
        launch(2, 1'b0);
        check_run("oneshot", -1, -1, -1);
    endtask

    task automatic test_loop();
        build_run(2, 1'b1, 15, -1, 0);
        launch(2, 1'b1);
        check_run("loop", 15, -1, -1);
    endtask

    task automatic test_contention();
        obs_t o;
        @(negedge sync_clk);
        last_idx = 2;
        loop_en  = 1'b0;
        start    = 1'b1;
        stop     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sync_clk);
            start = 1'b0;
            stop  = 1'b0;
            o = observe();
            checks++;
            if (o !== m_obs) begin
                failures++;
                $display("FAIL start_stop_idle cycle %0d: got %h want %h", i, o, m_obs);
            end
        end
        build_run(2, 1'b0, -1, -1, 0);
        launch(2, 1'b0);
        check_run("start_while_busy", -1, 6, -1);
    endtask

    task automatic test_live_write();
        logic [EW-1:0] new0;
        new0   = mk(3, 3, 3, 3, 0, 1);
        tbl[2] = mk(7, 2, 2, 2, 0, 5);
        build_run(2, 1'b0, -1, -1, 0);
        wr_at.push_back(3); wr_addr.push_back(2); wr_data.push_back(tbl[2]);
        wr_at.push_back(4); wr_addr.push_back(0); wr_data.push_back(new0);
        launch(2, 1'b0);
        check_run("live_write", -1, -1, -1);
        tbl[0] = new0;
    endtask

`ifdef PROFILE_SEQ_TRIG_EN
    task automatic test_trigger();
        load_entry(0, mk(1, 2, 3, 4, 0, 3));
        load_entry(1, mk(5, 6, 7, 0, 1, 2));
        load_entry(2, mk(2, 2, 2, 2, 0, 5));
        // entry 1 occupies cycles 6..8 on dwell, 9..11 waiting; trig after 11
        build_run(2, 1'b0, -1, 1, 3);
        launch(2, 1'b0);
        check_run("trigger", -1, -1, 11);
    endtask
`endif

    task automatic test_random();
        int lst;
        bit lp;
        int stop_at;
        int wt;
        for (int it = 0; it < 8; it++) begin
            lst = int'($urandom_range(5, 0));
            for (int e = 0; e <= lst; e++) begin
`ifdef PROFILE_SEQ_TRIG_EN
                wt = 0;
`else
                wt = int'($urandom_range(1, 0));
`endif
                load_entry(e, mk(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                                 int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                                 wt, int'($urandom_range(3, 0))));
            end
            lp      = 1'($urandom);
            stop_at = lp ? int'($urandom_range(40, 3)) : -1;
            build_run(lst, lp, stop_at, -1, 0);
            launch(lst, lp);
            check_run($sformatf("random%0d", it), stop_at, -1, -1);
        end
    endtask

    task automatic test_reset_midrun();
        obs_t o;
        obs_t z;
        z = '0;
        load_plan_table();
        launch(2, 1'b0);
        repeat (5) begin
            @(negedge sync_clk);
            start = 1'b0;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sync_clk);
            if (i == 1) rst = 1'b0;
            o = observe();
            checks++;
            if (o !== z) begin
                failures++;
                $display("FAIL reset_midrun cycle %0d: got %h want %h", i, o, z);
            end
        end
        m_obs = '0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_loop();
        test_contention();
        test_live_write();
`ifdef PROFILE_SEQ_TRIG_EN
        test_trigger();
`endif
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
